// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state codes, opcodes and datapath select encodings
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b10;
    localparam logic [1:0] SRCB_IMM     = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// rtl/ctrl_out_decode.sv - combinational state to control word decode
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: ctrl.i_or_d = 1'b1;
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// rtl/main_ctrl_fsm.sv - multicycle MIPS main control Moore FSM
module main_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [5:0] opcode_q;
    ctrl_word_t ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            opcode_q <= 6'b000000;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                opcode_q <= Opcode;
        end
    end

    // MEMADR steers on the opcode captured in DECODE, not the live IR bits
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode_q == OP_LW)
                    next_state = S_MEMREAD;
                else if (opcode_q == OP_SW)
                    next_state = S_MEMWRITE;
                else
                    next_state = S_FETCH;
            end
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ADDIEXEC: next_state = S_ADDIWB;
            default:    next_state = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign State       = state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// tb/tb_main_ctrl_fsm.sv - directed self-checking bench for main_ctrl_fsm
module tb_main_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'b000000;
    logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int passed = 0;
    int total  = 0;

    main_ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .State       (State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // advance to the next falling edge and check the state code there
    task automatic step_state(input string tag, input logic [3:0] exp);
        @(negedge clk);
        chk(tag, 8'(State), 8'(exp));
    endtask

    // RegWrite/MemWrite/PCWrite/PCWriteCond packed into one nibble
    function automatic logic [7:0] writes();
        return {4'b0000, RegWrite, MemWrite, PCWrite, PCWriteCond};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state",   8'(State),    8'd0);
        chk("rst_pcwrite", 8'(PCWrite),  8'd1);
        chk("rst_irwrite", 8'(IRWrite),  8'd1);
        chk("rst_srcb",    8'(ALUSrcB),  8'd1);
        chk("rst_memwr",   8'(MemWrite), 8'd0);
        chk("rst_regwr",   8'(RegWrite), 8'd0);
        reset = 1'b0;

        Opcode = 6'b100011;
        step_state("lw_s1", 4'd1);
        chk("lw_srcb1", 8'(ALUSrcB), 8'd2);
        step_state("lw_s2", 4'd2);
        chk("lw_srcb2", 8'(ALUSrcB), 8'd3);
        chk("lw_rw2",   8'(RegWrite), 8'd0);
        step_state("lw_s3", 4'd3);
        chk("lw_iord3", 8'(IorD), 8'd1);
        chk("lw_rw3",   8'(RegWrite), 8'd0);
        step_state("lw_s4", 4'd4);
        chk("lw_rw4",   8'(RegWrite), 8'd1);
        chk("lw_m2r4",  8'(MemtoReg), 8'd1);
        chk("lw_dst4",  8'(RegDst),   8'd0);
        step_state("lw_s0", 4'd0);
        chk("lw_m2r0",  8'(MemtoReg), 8'd0);

        Opcode = 6'b000000;
        step_state("r_s1", 4'd1);
        step_state("r_s6", 4'd6);
        chk("r_aluop6", 8'(ALUOp),   8'd2);
        chk("r_srca6",  8'(ALUSrcA), 8'd1);
        chk("r_srcb6",  8'(ALUSrcB), 8'd0);
        step_state("r_s7", 4'd7);
        chk("r_dst7",   8'(RegDst),   8'd1);
        chk("r_rw7",    8'(RegWrite), 8'd1);
        chk("r_m2r7",   8'(MemtoReg), 8'd0);
        step_state("r_s0", 4'd0);

        Opcode = 6'b000100;
        step_state("beq_s1", 4'd1);
        chk("beq_pwc1", 8'(PCWriteCond), 8'd0);
        step_state("beq_s8", 4'd8);
        chk("beq_pwc8",  8'(PCWriteCond), 8'd1);
        chk("beq_psrc8", 8'(PCSource),    8'd1);
        chk("beq_aluop", 8'(ALUOp),       8'd1);
        chk("beq_pcw8",  8'(PCWrite),     8'd0);
        step_state("beq_s0", 4'd0);
        chk("beq_pwc0", 8'(PCWriteCond), 8'd0);

        Opcode = 6'b000010;
        step_state("j_s1", 4'd1);
        step_state("j_s11", 4'd11);
        chk("j_psrc", 8'(PCSource),    8'd2);
        chk("j_pcw",  8'(PCWrite),     8'd1);
        chk("j_pwc",  8'(PCWriteCond), 8'd0);
        chk("j_irw",  8'(IRWrite),     8'd0);
        step_state("j_s0", 4'd0);

        Opcode = 6'b111111;
        step_state("ill_s1", 4'd1);
        chk("ill_wr1", writes(), 8'h00);
        step_state("ill_s0", 4'd0);
        chk("ill_wr0", writes(), 8'h02);

        Opcode = 6'b001000;
        step_state("addi_s1", 4'd1);
        step_state("addi_s9", 4'd9);
        chk("addi_srcb", 8'(ALUSrcB), 8'd3);
        chk("addi_rw9",  8'(RegWrite), 8'd0);
        step_state("addi_s10", 4'd10);
        chk("addi_rw10", 8'(RegWrite), 8'd1);
        chk("addi_dst",  8'(RegDst),   8'd0);
        step_state("addi_s0", 4'd0);

        Opcode = 6'b101011;
        step_state("sw_s1", 4'd1);
        step_state("sw_s2", 4'd2);
        Opcode = 6'b000000;
        step_state("sw_s5", 4'd5);
        chk("sw_memwr5", 8'(MemWrite), 8'd1);
        chk("sw_iord5",  8'(IorD),     8'd1);
        chk("sw_rw5",    8'(RegWrite), 8'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 8'(State),    8'd0);
        chk("arst_memwr", 8'(MemWrite), 8'd0);
        chk("arst_pcw",   8'(PCWrite),  8'd1);
        #1 reset = 1'b0;
        Opcode = 6'b111111;
        step_state("post_s1", 4'd1);
        step_state("post_s0", 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Opcode, input, 6, instruction bits [31:26] from IR, sampled in DECODE only.
REQ-004 SHALL have outputs PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, each 1 bit, multicycle datapath enables/selects.
REQ-005 SHALL have output ALUSrcB, 2 bits, ALU operand-B select: 00=B reg, 01=constant 4, 10=sign-extended imm shifted left 2, 11=sign-extended imm.
REQ-006 SHALL have outputs ALUOp (2 bits: 00 add, 01 sub, 10 funct-decode) and PCSource (2 bits: 00 ALU result, 01 ALUOut, 10 jump target).
REQ-007 SHALL have output State, 4 bits, current state code for debug.

Function
REQ-008 SHALL be a Moore FSM: registered state; all outputs decoded from current state only; unlisted outputs 0.
REQ-009 SHALL use state codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-010 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1; next DECODE.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00; next by Opcode: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEXEC, 000010->JUMP, any other->FETCH.
REQ-012 MEMADR: ALUSrcA=1, ALUSrcB=11, ALUOp=00; next MEMREAD if latched opcode is lw, MEMWRITE if sw.
REQ-013 MEMREAD: IorD=1; next MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-014 MEMWRITE: IorD=1, MemWrite=1; next FETCH.
REQ-015 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1; next FETCH.
REQ-017 ADDIEXEC: ALUSrcA=1, ALUSrcB=11, ALUOp=00; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-018 JUMP: PCSource=10, PCWrite=1; next FETCH.
REQ-019 SHALL latch Opcode into an internal register on DECODE so MEMADR decision is immune to IR changes.
REQ-020 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2 (no write enables asserted).
REQ-021 Any unused state code (12-15) SHALL transition to FETCH with all outputs 0.
REQ-022 MemWrite, RegWrite, PCWrite, IRWrite SHALL never be asserted in the same state as each other except PCWrite+IRWrite in FETCH.

Reset
REQ-023 reset=1 SHALL force state to FETCH immediately, independent of clk; latched opcode cleared to 000000.
REQ-024 During reset outputs SHALL equal FETCH values (REQ-010); first rising clk after deassertion SHALL execute FETCH.
REQ-025 Reset mid-instruction SHALL abandon the instruction with no further write enables beyond FETCH.

Structure
REQ-026 State codes, opcode constants, ALUSrcB/ALUOp/PCSource encodings SHALL live in shared package mips_ctrl_pkg, reused by datapath muxes.
REQ-027 One sub-module SHALL be natural: ctrl_out_decode (state -> control word, combinational); next-state logic stays in main_ctrl_fsm.

Verification
REQ-028 Assert reset, hold 3 cycles -> State=0, PCWrite=1, IRWrite=1, ALUSrcB=01, MemWrite=0, RegWrite=0.
REQ-029 Opcode=100011 after reset -> States 0,1,2,3,4,0; ALUSrcB 01,10,11,00(don't care),00; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-030 Opcode=000000 -> States 0,1,6,7,0; ALUOp=10 in 6; RegDst=1, RegWrite=1 in 7.
REQ-031 Opcode=000100 then 000010 -> States 0,1,8,0,1,11,0; PCWriteCond=1 only in 8; PCSource=10, PCWrite=1 in 11.
REQ-032 Opcode=111111 -> States 0,1,0 with MemWrite, RegWrite, PCWriteCond all 0 throughout.
REQ-033 Opcode=101011, change Opcode to 000000 in state 2, pulse reset in state 5 asynchronously -> state 2->5 (not 6), State=0 within same cycle, MemWrite drops to 0 immediately.
